dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port data RAM between the pipeline's memory stage (CPU port) and an external loader/DMA port. Grants one access per cycle, holds the pipeline with a stall when the CPU loses arbitration, and routes the synchronous-read data back to its owner one cycle later. CPU has fixed priority, with a starvation counter that forces a DMA grant after a bounded wait.

## Interface
- DMEM_POWER, 18, log2 of RAM depth in words
- STARVE_LIMIT, 4, consecutive denied DMA cycles before DMA is forced through; legal range 1..255

- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately
- cpuReqM  input  1  memory-stage access request (memWrite or mem2reg)
- cpuWeM  input  1  1 = write, 0 = read
- cpuAddrM  input  `WORD  byte address (ALU result)
- cpuWdataM  input  `WORD  store data
- cpuStallM  output  1  hold fetch..memory stages this cycle
- cpuRvalid  output  1  cpuRdata valid
- cpuRdata  output  `WORD  load data
- dmaReq  input  1  DMA request; held with payload until granted
- dmaWe  input  1  1 = write
- dmaAddr  input  `WORD  byte address
- dmaWdata  input  `WORD  write data
- dmaGnt  output  1  request accepted this cycle
- dmaRvalid  output  1  dmaRdata valid
- dmaRdata  output  `WORD  read data
- ramWe  output  1  RAM write enable
- ramAddr  output  DMEM_POWER  RAM word address
- ramWdata  output  `WORD  RAM write data
- ramRdata  input  `WORD  RAM read data, synchronous, 1-cycle latency

## Operation
- Word address = byteAddr[DMEM_POWER+1:2]; bits [1:0] ignored; upper bits beyond RAM ignored (wrap).
- State: waitCnt (saturating, $clog2(STARVE_LIMIT+1) bits), rdOwner (CPU/DMA), rdPend (1 bit).
- Grant (combinational from inputs and registered waitCnt):
  - force = dmaReq & (waitCnt == STARVE_LIMIT)
  - cpuGnt = cpuReqM & ~force; dmaGnt = dmaReq & ~cpuGnt
- cpuStallM = cpuReqM & ~cpuGnt.
- RAM mux: granted port drives ramAddr/ramWdata; ramWe = granted & granted port's We; no grant -> ramWe=0, ramAddr=0, ramWdata=0.
- waitCnt next: dmaReq & ~dmaGnt -> min(waitCnt+1, STARVE_LIMIT); otherwise 0.
- Read tracking: rdPend <= granted read this cycle; rdOwner <= owner of that read.
- Return: cpuRvalid = rdPend & rdOwner==CPU; dmaRvalid = rdPend & rdOwner==DMA; each Rdata = its Rvalid ? ramRdata : 0.
- Writes produce no Rvalid. Write then read of same address on consecutive grants returns the new data (RAM write-first not required; ordering by cycle suffices).

## Timing
- Reset (reset=0): waitCnt=0, rdPend=0, rdOwner=CPU; therefore cpuRvalid=0, dmaRvalid=0, both Rdata=0. Combinational outputs follow inputs (cpuStallM=cpuReqM&force is 0 since waitCnt=0).
- Grant, stall, RAM command: same cycle as request (0 latency).
- Read data: Rvalid asserted exactly 1 cycle after the granting cycle; back-to-back reads give Rvalid every cycle.
- Worst-case DMA wait under continuous CPU requests: STARVE_LIMIT cycles, granted in cycle STARVE_LIMIT (counting from 0).
- Forced DMA cycle stalls CPU one cycle; waitCnt returns to 0 next cycle.
- DMA must hold dmaReq/payload until dmaGnt; dropping dmaReq clears waitCnt.
- Reset asserted mid-read: pending return discarded, no Rvalid after deassertion.
- Both idle: no RAM write, no Rvalid next cycle.

## Test plan
- Reset: hold reset=0 with ramRdata=0xDEADBEEF, random requests -> cpuRvalid=dmaRvalid=0, cpuRdata=dmaRdata=0.
- CPU only: write 0x12345678 to byte 0x40, next cycle read 0x40 -> ramAddr=0x10, ramWe=1 then 0, cpuRvalid=1 one cycle later with 0x12345678, cpuStallM=0 throughout.
- Simultaneous single request, waitCnt=0: CPU read 0x8, DMA read 0xC -> cpuGnt, dmaGnt=0, cpuStallM=0; next cycle CPU idle -> dmaGnt=1, dmaRvalid the cycle after.
- Starvation, STARVE_LIMIT=4: CPU and DMA request every cycle from cycle 0 -> dmaGnt=0 cycles 0-3, dmaGnt=1 and cpuStallM=1 in cycle 4, CPU granted again cycle 5.
- Read return routing: CPU read cycle n, DMA read forced cycle n+1 -> cpuRvalid only at n+1, dmaRvalid only at n+2, no overlap.
- Reset mid-read: CPU read granted, reset=0 before next edge, release -> cpuRvalid never asserts; waitCnt=0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, DMA and RAM port bundle of the data-memory arbiter
interface dmem_arbiter_if #(
    parameter int DMEM_POWER = 18,
    parameter int WORD_W     = 32
);
    // CPU memory-stage port
    logic                  cpuReqM;
    logic                  cpuWeM;
    logic [WORD_W-1:0]     cpuAddrM;
    logic [WORD_W-1:0]     cpuWdataM;
    logic                  cpuStallM;
    logic                  cpuRvalid;
    logic [WORD_W-1:0]     cpuRdata;
    // Loader / DMA port
    logic                  dmaReq;
    logic                  dmaWe;
    logic [WORD_W-1:0]     dmaAddr;
    logic [WORD_W-1:0]     dmaWdata;
    logic                  dmaGnt;
    logic                  dmaRvalid;
    logic [WORD_W-1:0]     dmaRdata;
    // Single-port RAM
    logic                  ramWe;
    logic [DMEM_POWER-1:0] ramAddr;
    logic [WORD_W-1:0]     ramWdata;
    logic [WORD_W-1:0]     ramRdata;

    modport slave (
        input  cpuReqM, cpuWeM, cpuAddrM, cpuWdataM,
        output cpuStallM, cpuRvalid, cpuRdata,
        input  dmaReq, dmaWe, dmaAddr, dmaWdata,
        output dmaGnt, dmaRvalid, dmaRdata,
        output ramWe, ramAddr, ramWdata,
        input  ramRdata
    );

    modport master (
        output cpuReqM, cpuWeM, cpuAddrM, cpuWdataM,
        input  cpuStallM, cpuRvalid, cpuRdata,
        output dmaReq, dmaWe, dmaAddr, dmaWdata,
        input  dmaGnt, dmaRvalid, dmaRdata,
        input  ramWe, ramAddr, ramWdata,
        output ramRdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority data RAM arbiter with DMA starvation guard
module dmem_arbiter #(
    parameter int DMEM_POWER   = 18,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int                CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT     = CNT_W'(STARVE_LIMIT);
    localparam logic              OWNER_CPU = 1'b0;
    localparam logic              OWNER_DMA = 1'b1;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_owner_q, rd_owner_d;
    logic             force_dma, cpu_gnt, dma_gnt;
    logic             ram_we;
    logic [DMEM_POWER-1:0] ram_addr;
    logic [31:0]      ram_wdata;
    logic             cpu_rvalid, dma_rvalid;

    // Byte-lane bits and address bits above the RAM depth are deliberately dropped
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.cpuAddrM[1:0], bus.cpuAddrM[31:DMEM_POWER+2],
                                bus.dmaAddr[1:0],  bus.dmaAddr[31:DMEM_POWER+2]};

    // CPU wins unless the DMA has waited STARVE_LIMIT cycles in a row
    always_comb begin
        force_dma = bus.dmaReq & (wait_cnt_q == LIMIT);
        cpu_gnt   = bus.cpuReqM & ~force_dma;
        dma_gnt   = bus.dmaReq & ~cpu_gnt;
    end

    // Granted port owns the RAM command; idle cycles drive an all-zero command
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (cpu_gnt) begin
            ram_we    = bus.cpuWeM;
            ram_addr  = bus.cpuAddrM[DMEM_POWER+1:2];
            ram_wdata = bus.cpuWdataM;
        end else if (dma_gnt) begin
            ram_we    = bus.dmaWe;
            ram_addr  = bus.dmaAddr[DMEM_POWER+1:2];
            ram_wdata = bus.dmaWdata;
        end
    end

    // Starvation count grows while DMA is refused and remembers who gets the next read return
    always_comb begin
        wait_cnt_d = '0;
        if (bus.dmaReq & ~dma_gnt) begin
            wait_cnt_d = (wait_cnt_q == LIMIT) ? LIMIT : wait_cnt_q + 1'b1;
        end
        rd_pend_d  = (cpu_gnt & ~bus.cpuWeM) | (dma_gnt & ~bus.dmaWe);
        rd_owner_d = cpu_gnt ? OWNER_CPU : OWNER_DMA;
    end

    // Arbiter state; reset discards any read return still in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWNER_CPU;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign cpu_rvalid    = rd_pend_q & (rd_owner_q == OWNER_CPU);
    assign dma_rvalid    = rd_pend_q & (rd_owner_q == OWNER_DMA);

    assign bus.cpuStallM = bus.cpuReqM & ~cpu_gnt;
    assign bus.dmaGnt    = dma_gnt;
    assign bus.ramWe     = ram_we;
    assign bus.ramAddr   = ram_addr;
    assign bus.ramWdata  = ram_wdata;
    assign bus.cpuRvalid = cpu_rvalid;
    assign bus.dmaRvalid = dma_rvalid;
    assign bus.cpuRdata  = cpu_rvalid ? bus.ramRdata : '0;
    assign bus.dmaRdata  = dma_rvalid ? bus.ramRdata : '0;
endmodule
